hack_memory: RTL

// - Data-memory responder on the CPU's M-bus: services addressM/outM/writeM and returns inM.
// - Maps RAM, screen buffer and keyboard register into the Hack address space.
// - Accepts key codes over a valid/ready handshake.
// - Optionally streams the screen buffer to a display sink.

---
 rtl/hack_memory.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/hack_memory.sv
// Hack data memory: RAM, screen buffer and keyboard register on the CPU M-bus.
// Optional screen scanner is built when HACK_MEM_SCAN_EN is defined.
module hack_memory #(
    parameter int unsigned RAM_WORDS    = 16384,
    parameter int unsigned SCREEN_WORDS = 8192,
    parameter logic [15:0] KBD_ADDR     = 16'h6000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    input  logic [15:0] kbd_code,
    input  logic        kbd_valid,
    output logic        kbd_ready,
`ifdef HACK_MEM_SCAN_EN
    output logic [15:0] scan_word,
    output logic [7:0]  scan_row,
    output logic [4:0]  scan_col,
    output logic        scan_valid,
    input  logic        scan_ready,
    output logic        scan_frame,
`endif
    output logic [15:0] inM
);

    localparam int unsigned RamAw = $clog2(RAM_WORDS);
    localparam int unsigned ScrAw = $clog2(SCREEN_WORDS);
    localparam logic [15:0] ScrBase = 16'h4000;
    localparam logic [15:0] ScrEnd  = ScrBase + 16'(SCREEN_WORDS);

    logic [15:0] ram_q [RAM_WORDS];
    logic [15:0] scr_q [SCREEN_WORDS];
    logic [15:0] kbd_q;
    logic [15:0] kbd_d;

    logic [15:0]      addr_full;
    logic [15:0]      scr_off;
    logic [RamAw-1:0] ram_idx;
    logic [ScrAw-1:0] scr_idx;
    logic             is_ram;
    logic             is_scr;
    logic             is_kbd;
    logic             unused_scr_off;

    // Address decode
    always_comb begin
        addr_full = {1'b0, addressM};
        scr_off   = addr_full - ScrBase;
        ram_idx   = addressM[RamAw-1:0];
        scr_idx   = scr_off[ScrAw-1:0];
        is_ram    = (addr_full < ScrBase);
        is_scr    = (addr_full >= ScrBase) && (addr_full < ScrEnd);
        is_kbd    = (addr_full == KBD_ADDR);
    end

    assign unused_scr_off = ^scr_off[15:ScrAw];

    // Memory writes are not gated by reset: contents survive and writes during reset land.
    always_ff @(posedge clk) begin
        if (writeM && is_ram) begin
            ram_q[ram_idx] <= outM;
        end
        if (writeM && is_scr) begin
            scr_q[scr_idx] <= outM;
        end
    end

    always_comb begin
        inM = 16'h0000;
        if (is_ram) begin
            inM = ram_q[ram_idx];
        end else if (is_scr) begin
            inM = scr_q[scr_idx];
        end else if (is_kbd) begin
            inM = kbd_q;
        end
    end

    // Keyboard register
    assign kbd_ready = reset;

    always_comb begin
        kbd_d = kbd_q;
        if (kbd_valid && kbd_ready) begin
            kbd_d = kbd_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            kbd_q <= 16'h0000;
        end else begin
            kbd_q <= kbd_d;
        end
    end

`ifdef HACK_MEM_SCAN_EN
    typedef enum logic {
        StIdle,
        StShow
    } scan_st_e;

    scan_st_e    state_q;
    scan_st_e    state_d;
    logic [12:0] idx_q;
    logic [12:0] idx_d;
    logic [15:0] word_q;
    logic [15:0] word_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        unique case (state_q)
            StIdle: begin
                word_d  = scr_q[idx_q[ScrAw-1:0]];
                state_d = StShow;
            end
            StShow: begin
                if (scan_ready) begin
                    idx_d  = (idx_q == 13'(SCREEN_WORDS - 1)) ? 13'd0 : idx_q + 13'd1;
                    word_d = scr_q[idx_d[ScrAw-1:0]];
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Array read precedes the same-edge CPU write, so a colliding load sees the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= 13'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    assign scan_word  = word_q;
    assign scan_row   = idx_q[12:5];
    assign scan_col   = idx_q[4:0];
    assign scan_valid = (state_q == StShow);
    assign scan_frame = scan_valid && (idx_q == 13'd0);
`endif

endmodule
